// File: rtl/led_pkg.sv
// Shared types for the LED event blinker: FSM state encoding and led[] bit positions.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int BLINK_BIT = 0;
  localparam int BUSY_BIT  = 1;
  localparam int OVF_BIT   = 2;
  localparam int DONE_BIT  = 3;
  localparam int PEND_LSB  = 4;

endpackage

// File: rtl/sat_counter.sv
// Up/down saturating counter with a sticky overflow flag, set when an increment is dropped at full scale.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  // Simultaneous inc and dec cancel, so a full counter never flags overflow then.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == MAX) ovf_d = 1'b1;
      else              cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/led_event_blinker.sv
// Turns single-cycle event strobes into visible blinks on led[7:0], queueing events that arrive mid-blink.
// Optional LED_BLINK_CLEAR_EN adds clr_i to flush the queue and the sticky overflow flag.
module led_event_blinker
  import led_pkg::*;
#(
  parameter int ON_CYCLES  = 50000000,
  parameter int OFF_CYCLES = 25000000,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_i,
`ifdef LED_BLINK_CLEAR_EN
  input  logic              clr_i,
`endif
  output logic [7:0]        led,
  output logic [PEND_W-1:0] pending_o,
  output logic              done_o
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              blink_q, blink_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tog_q, tog_d;
  logic [PEND_W-1:0] pend_q;
  logic              ovf_q;
  logic              last_gap, pend_nz, inc, dec, clr;

`ifdef LED_BLINK_CLEAR_EN
  assign clr = clr_i;
`else
  assign clr = 1'b0;
`endif

  assign last_gap = (state_q == ST_GAP) && (timer_q == '0);
  assign pend_nz  = (pend_q != '0);
  // An event on the final gap cycle with an empty queue starts the next blink directly instead of queueing.
  assign inc      = evt_i && (state_q != ST_IDLE) && !(last_gap && !pend_nz);
  assign dec      = last_gap && pend_nz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      blink_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tog_q   <= tog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (evt_i) begin
          state_d = ST_ON;
          timer_d = ON_LOAD;
        end
      end
      ST_ON: begin
        if (timer_q == '0) begin
          state_d = ST_GAP;
          timer_d = OFF_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          if (pend_nz || evt_i) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so every pin comes straight from a flop.
  always_comb begin
    blink_d = (state_d == ST_ON);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_GAP) && (timer_d == '0);
    tog_d   = tog_q ^ last_gap;
  end

  sat_counter #(
    .W(PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .inc_i (inc),
    .dec_i (dec),
    .cnt_o (pend_q),
    .ovf_o (ovf_q)
  );

  assign led[BLINK_BIT]      = blink_q;
  assign led[BUSY_BIT]       = busy_q;
  assign led[OVF_BIT]        = ovf_q;
  assign led[DONE_BIT]       = tog_q;
  assign led[PEND_LSB +: 4]  = 4'(pend_q);
  assign pending_o           = pend_q;
  assign done_o              = done_q;

endmodule
